small_fv_stream_rcvr: RTL and testbench
=======================================

Name: small_fv_stream_rcvr

Overview:
- Receiving end of the Big-FV-to-Small-FV stream (sos/eos/A/FV_data) driven by the big feature-value bank controller.
- Writes each streamed line into the local small FV SRAM bank, then marks the iteration's feature set loaded.
- Serves Edge PE read requests from that bank with an sos/eos framed response stream.

Parameters:
- FV_BW, 64, feature-value line width (bits), equals FV_bandwidth.
- NODE_W, 4, node-index field width inside A (log2 MAX_NODE_PER_ITER_BANK).
- LINE_W, 3, line-within-node field width (log2 Max_FV_num/2).
- FVNUM_W, 5, width of fv_num (log2 Max_FV_num + 1).
- TAG_W, 2, Edge PE tag width (log2 Num_Edge_PE).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- st_sos  in  1  stream start; qualifies the first line.
- st_eos  in  1  stream end; qualifies the last line.
- st_A  in  NODE_W+LINE_W  line address {node, line}.
- st_FV_data  in  FV_BW  streamed line.
- fv_num  in  FVNUM_W  feature values per node (2 per line).
- rd_req  in  1  Edge PE read request, single-cycle pulse.
- rd_node  in  NODE_W  node to read.
- rd_PE_tag  in  TAG_W  requester tag.
- rd_ready  out  1  bank loaded, no read in flight.
- sram_CEN  out  1  active-low chip enable.
- sram_WEN  out  1  active-low write enable.
- sram_addr  out  NODE_W+LINE_W  SRAM address.
- sram_D  out  FV_BW  SRAM write data.
- sram_Q  in  FV_BW  SRAM read data, 1-cycle latency.
- pe_sos, pe_eos  out  1  response framing.
- pe_FV_data  out  FV_BW  response line.
- pe_PE_tag  out  TAG_W  echoed tag.
- rd_abort  out  1  read killed by an incoming stream, 1-cycle pulse.

Behaviour:
- Reset (async, reset_n=0): state IDLE; sram_CEN=1, sram_WEN=1, sram_addr=0, sram_D=0; all pe_* = 0; rd_ready=0, rd_abort=0; counters and tag cleared. Outputs are combinational from state and registers; registers update on posedge clk.
- States: IDLE, LOAD, READY, RD.
- IDLE: st_sos -> LOAD; the sos line is written the same cycle (CEN=0, WEN=0, addr=st_A, D=st_FV_data). sos with eos together is a one-line stream: write, go to READY.
- LOAD: every cycle writes st_FV_data at st_A (the stream has no backpressure and no idle cycles). st_eos: write the last line, go to READY. rd_req ignored, rd_ready=0.
- READY: rd_ready=1. rd_req: latch rd_node and rd_PE_tag; nlines = ceil(fv_num/2) = (fv_num+1)>>1, computed FVNUM_W wide; issue read addr {rd_node,0}; line counter=1; go to RD.
- RD: while counter < nlines, issue read {node, counter}, counter++. Each cycle after the first read, present sram_Q on pe_FV_data with pe_PE_tag. pe_sos on the first data cycle; pe_eos on the data cycle of line nlines-1, then READY. nlines=1 gives sos and eos in the same cycle. Latency rd_req -> pe_sos = 2 cycles. rd_req during RD is ignored.
- fv_num=0 in READY with rd_req: no read, pe_sos=pe_eos=1 with data 0, return to READY.
- st_sos in READY or RD: stream wins. In RD the read is aborted: rd_abort=1 for that cycle, no pe_eos, pe_* = 0 from that cycle. Go to LOAD and write the sos line that cycle.
- st_sos while in LOAD: treated as a data line (written), no state change.
- Counter wraps at 2^LINE_W are impossible for legal fv_num; not checked unless the optional feature is enabled.
- READY persists until the next st_sos; the bank holds the last loaded iteration.

Optional Feature:
- Macro: SMFV_STREAM_CHK_EN.
- Compiled in: adds output proto_err (1, sticky until reset). Set on any of:
  - st_sos while in LOAD;
  - st_eos outside LOAD without st_sos;
  - LOAD st_A not equal to the previous st_A+1 within a node, or line field not 0 on a node change;
  - fv_num > 2^(LINE_W+1) at rd_req.
- Compiled out: no port, no checks; behaviour otherwise identical.

Decomposition:
- Shared package: stream packet typedef {sos, eos, A, FV_data} (same as the big-bank output), Edge PE response typedef {sos, eos, FV_data, PE_tag}, state enum, line-count function ceil(fv_num/2).
- One natural sub-module: small_fv_rd_seq (READY/RD read sequencer with counter and 1-cycle data alignment). Stream write path stays in the top.

Test Plan:
- Load: sos at A=0x00, lines 0x00..0x0F, eos at A=0x0F with data=addr -> 16 writes CEN=0/WEN=0 at matching addrs, rd_ready=1 the cycle after eos.
- Read fv_num=16, rd_node=1, tag=2 -> reads 0x08..0x0F; pe_sos 2 cycles after rd_req, 8 data beats 0x08..0x0F, pe_eos on beat 8, pe_PE_tag=2.
- Read fv_num=5 -> nlines=3; beats 3; fv_num=2 -> single beat with sos=eos=1.
- st_sos during RD beat 2 -> rd_abort=1 that cycle, no pe_eos, write at st_A same cycle, state LOAD.
- reset_n low mid-LOAD (async, between edges) -> outputs at reset values immediately; rd_req after release ignored until a new sos/eos load.
- SMFV_STREAM_CHK_EN: skip A from 0x03 to 0x05 -> proto_err=1 and held; without macro, same stimulus writes normally.

Source files
------------

// File: rtl/small_fv_stream_rcvr_pkg.sv
// rtl/small_fv_stream_rcvr_pkg.sv - shared types, widths and line-count helper for the small FV receiver
package small_fv_stream_rcvr_pkg;

    localparam int FV_BW   = 64;
    localparam int NODE_W  = 4;
    localparam int LINE_W  = 3;
    localparam int FVNUM_W = 5;
    localparam int TAG_W   = 2;
    localparam int A_W     = NODE_W + LINE_W;

    // Largest fv_num that still fits in 2^LINE_W lines of two values each
    localparam logic [FVNUM_W-1:0] FVNUM_MAX = FVNUM_W'(2 ** (LINE_W + 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RD    = 2'd3
    } state_e;

    typedef struct packed {
        logic             sos;
        logic             eos;
        logic [A_W-1:0]   A;
        logic [FV_BW-1:0] FV_data;
    } fv_stream_t;

    typedef struct packed {
        logic             sos;
        logic             eos;
        logic [FV_BW-1:0] FV_data;
        logic [TAG_W-1:0] PE_tag;
    } pe_rsp_t;

    function automatic logic [FVNUM_W-1:0] line_count(input logic [FVNUM_W-1:0] fv_num);
        logic [FVNUM_W-1:0] sum;
        sum = fv_num + FVNUM_W'(1);
        return sum >> 1;
    endfunction

endpackage

// File: rtl/small_fv_rd_seq.sv
// rtl/small_fv_rd_seq.sv - read sequencer: issues node lines to the SRAM and frames the aligned response
module small_fv_rd_seq
    import small_fv_stream_rcvr_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NODE_W-1:0]  rd_node,
    input  logic [TAG_W-1:0]   rd_PE_tag,
    input  logic [FVNUM_W-1:0] fv_num,
    input  logic [FV_BW-1:0]   sram_Q,
    output logic               rd_en,
    output logic [A_W-1:0]     rd_addr,
    output pe_rsp_t            rsp,
    output logic               done
);

    logic [NODE_W-1:0]  node_q, node_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [FVNUM_W-1:0] nlines_q, nlines_d;
    logic [FVNUM_W-1:0] cnt_q, cnt_d;
    logic               cap_vld_q, cap_vld_d;
    logic               cap_first_q, cap_first_d;
    logic               cap_last_q, cap_last_d;
    logic               cap_zero_q, cap_zero_d;
    logic               out_vld_q, out_vld_d;
    logic               out_sos_q, out_sos_d;
    logic               out_eos_q, out_eos_d;
    logic [FV_BW-1:0]   out_data_q, out_data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            node_q      <= '0;
            tag_q       <= '0;
            nlines_q    <= '0;
            cnt_q       <= '0;
            cap_vld_q   <= 1'b0;
            cap_first_q <= 1'b0;
            cap_last_q  <= 1'b0;
            cap_zero_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            out_sos_q   <= 1'b0;
            out_eos_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            node_q      <= node_d;
            tag_q       <= tag_d;
            nlines_q    <= nlines_d;
            cnt_q       <= cnt_d;
            cap_vld_q   <= cap_vld_d;
            cap_first_q <= cap_first_d;
            cap_last_q  <= cap_last_d;
            cap_zero_q  <= cap_zero_d;
            out_vld_q   <= out_vld_d;
            out_sos_q   <= out_sos_d;
            out_eos_q   <= out_eos_d;
            out_data_q  <= out_data_d;
        end
    end

    // Issue stage: one line per cycle until the counter reaches nlines
    always_comb begin
        logic [FVNUM_W-1:0] nl;
        nl          = line_count(fv_num);
        node_d      = node_q;
        tag_d       = tag_q;
        nlines_d    = nlines_q;
        cnt_d       = cnt_q;
        cap_vld_d   = 1'b0;
        cap_first_d = 1'b0;
        cap_last_d  = 1'b0;
        cap_zero_d  = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        if (abort) begin
            nlines_d = '0;
            cnt_d    = '0;
            tag_d    = '0;
        end else if (start) begin
            node_d      = rd_node;
            tag_d       = rd_PE_tag;
            nlines_d    = nl;
            cap_vld_d   = 1'b1;
            cap_first_d = 1'b1;
            if (nl == '0) begin
                cnt_d      = '0;
                cap_zero_d = 1'b1;
                cap_last_d = 1'b1;
            end else begin
                rd_en      = 1'b1;
                rd_addr    = {rd_node, LINE_W'(0)};
                cnt_d      = FVNUM_W'(1);
                cap_last_d = (nl == FVNUM_W'(1));
            end
        end else if (cnt_q < nlines_q) begin
            rd_en      = 1'b1;
            rd_addr    = {node_q, cnt_q[LINE_W-1:0]};
            cnt_d      = cnt_q + FVNUM_W'(1);
            cap_vld_d  = 1'b1;
            cap_last_d = (cnt_q == nlines_q - FVNUM_W'(1));
        end
    end

    // Output stage registers sram_Q so the response lands two cycles after the request
    always_comb begin
        out_vld_d  = 1'b0;
        out_sos_d  = 1'b0;
        out_eos_d  = 1'b0;
        out_data_d = '0;
        if (!abort && cap_vld_q) begin
            out_vld_d  = 1'b1;
            out_sos_d  = cap_first_q;
            out_eos_d  = cap_last_q;
            out_data_d = cap_zero_q ? '0 : sram_Q;
        end
    end

    always_comb begin
        rsp         = '0;
        done        = 1'b0;
        if (out_vld_q && !abort) begin
            rsp.sos     = out_sos_q;
            rsp.eos     = out_eos_q;
            rsp.FV_data = out_data_q;
            rsp.PE_tag  = tag_q;
            done        = out_eos_q;
        end
    end

endmodule

// File: rtl/small_fv_stream_rcvr.sv
// rtl/small_fv_stream_rcvr.sv - small FV bank stream writer and Edge PE read server; SMFV_STREAM_CHK_EN adds proto_err
module small_fv_stream_rcvr
    import small_fv_stream_rcvr_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               st_sos,
    input  logic               st_eos,
    input  logic [A_W-1:0]     st_A,
    input  logic [FV_BW-1:0]   st_FV_data,
    input  logic [FVNUM_W-1:0] fv_num,
    input  logic               rd_req,
    input  logic [NODE_W-1:0]  rd_node,
    input  logic [TAG_W-1:0]   rd_PE_tag,
    output logic               rd_ready,
    output logic               sram_CEN,
    output logic               sram_WEN,
    output logic [A_W-1:0]     sram_addr,
    output logic [FV_BW-1:0]   sram_D,
    input  logic [FV_BW-1:0]   sram_Q,
    output logic               pe_sos,
    output logic               pe_eos,
    output logic [FV_BW-1:0]   pe_FV_data,
    output logic [TAG_W-1:0]   pe_PE_tag,
    output logic               rd_abort
`ifdef SMFV_STREAM_CHK_EN
    ,
    output logic               proto_err
`endif
);

    state_e     state_q, state_d;
    fv_stream_t st_pkt;
    pe_rsp_t    rsp;
    logic       wr_en;
    logic       seq_start;
    logic       seq_abort;
    logic       seq_rd_en;
    logic       seq_done;
    logic [A_W-1:0] seq_rd_addr;

    assign st_pkt = '{sos: st_sos, eos: st_eos, A: st_A, FV_data: st_FV_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An incoming stream always wins over a pending or running read
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (st_pkt.sos) state_d = st_pkt.eos ? ST_READY : ST_LOAD;
            end
            ST_LOAD: begin
                if (st_pkt.eos) state_d = ST_READY;
            end
            ST_READY: begin
                if (st_pkt.sos)  state_d = st_pkt.eos ? ST_READY : ST_LOAD;
                else if (rd_req) state_d = ST_RD;
            end
            ST_RD: begin
                if (st_pkt.sos)    state_d = st_pkt.eos ? ST_READY : ST_LOAD;
                else if (seq_done) state_d = ST_READY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en      = (state_q == ST_LOAD) || st_pkt.sos;
        seq_start  = (state_q == ST_READY) && rd_req && !st_pkt.sos;
        seq_abort  = (state_q == ST_RD) && st_pkt.sos;
        rd_ready   = (state_q == ST_READY);
        rd_abort   = seq_abort;
        sram_CEN   = 1'b1;
        sram_WEN   = 1'b1;
        sram_addr  = '0;
        sram_D     = '0;
        if (wr_en) begin
            sram_CEN  = 1'b0;
            sram_WEN  = 1'b0;
            sram_addr = st_pkt.A;
            sram_D    = st_pkt.FV_data;
        end else if (seq_rd_en) begin
            sram_CEN  = 1'b0;
            sram_addr = seq_rd_addr;
        end
        pe_sos     = rsp.sos;
        pe_eos     = rsp.eos;
        pe_FV_data = rsp.FV_data;
        pe_PE_tag  = rsp.PE_tag;
    end

    small_fv_rd_seq u_rd_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (seq_start),
        .abort     (seq_abort),
        .rd_node   (rd_node),
        .rd_PE_tag (rd_PE_tag),
        .fv_num    (fv_num),
        .sram_Q    (sram_Q),
        .rd_en     (seq_rd_en),
        .rd_addr   (seq_rd_addr),
        .rsp       (rsp),
        .done      (seq_done)
    );

`ifdef SMFV_STREAM_CHK_EN
    logic           err_q, err_d;
    logic [A_W-1:0] prev_a_q, prev_a_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q    <= 1'b0;
            prev_a_q <= '0;
        end else begin
            err_q    <= err_d;
            prev_a_q <= prev_a_d;
        end
    end

    // Within a node lines must be consecutive; a new node must start at line 0
    always_comb begin
        err_d    = err_q;
        prev_a_d = prev_a_q;
        if (wr_en) prev_a_d = st_A;
        if (state_q == ST_LOAD && st_sos) err_d = 1'b1;
        if (state_q != ST_LOAD && st_eos && !st_sos) err_d = 1'b1;
        if (state_q == ST_LOAD) begin
            if (st_A[A_W-1:LINE_W] == prev_a_q[A_W-1:LINE_W]) begin
                if (st_A[LINE_W-1:0] != prev_a_q[LINE_W-1:0] + LINE_W'(1)) err_d = 1'b1;
            end else if (st_A[LINE_W-1:0] != '0) begin
                err_d = 1'b1;
            end
        end
        if (seq_start && fv_num > FVNUM_MAX) err_d = 1'b1;
    end

    assign proto_err = err_q;
`endif

endmodule

// File: tb/tb_small_fv_stream_rcvr.sv
// tb/tb_small_fv_stream_rcvr.sv - directed self-checking bench for small_fv_stream_rcvr
module tb_small_fv_stream_rcvr;
    import small_fv_stream_rcvr_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               st_sos, st_eos;
    logic [A_W-1:0]     st_A;
    logic [FV_BW-1:0]   st_FV_data;
    logic [FVNUM_W-1:0] fv_num;
    logic               rd_req;
    logic [NODE_W-1:0]  rd_node;
    logic [TAG_W-1:0]   rd_PE_tag;
    logic               rd_ready, sram_CEN, sram_WEN;
    logic [A_W-1:0]     sram_addr;
    logic [FV_BW-1:0]   sram_D, sram_Q;
    logic               pe_sos, pe_eos, rd_abort;
    logic [FV_BW-1:0]   pe_FV_data;
    logic [TAG_W-1:0]   pe_PE_tag;
`ifdef SMFV_STREAM_CHK_EN
    logic               proto_err;
`endif

    logic [FV_BW-1:0]   mem [0:(1<<A_W)-1];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_CEN) begin
            if (!sram_WEN) mem[sram_addr] <= sram_D;
            else           sram_Q <= mem[sram_addr];
        end
    end

    small_fv_stream_rcvr dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .st_sos     (st_sos),
        .st_eos     (st_eos),
        .st_A       (st_A),
        .st_FV_data (st_FV_data),
        .fv_num     (fv_num),
        .rd_req     (rd_req),
        .rd_node    (rd_node),
        .rd_PE_tag  (rd_PE_tag),
        .rd_ready   (rd_ready),
        .sram_CEN   (sram_CEN),
        .sram_WEN   (sram_WEN),
        .sram_addr  (sram_addr),
        .sram_D     (sram_D),
        .sram_Q     (sram_Q),
        .pe_sos     (pe_sos),
        .pe_eos     (pe_eos),
        .pe_FV_data (pe_FV_data),
        .pe_PE_tag  (pe_PE_tag),
        .rd_abort   (rd_abort)
`ifdef SMFV_STREAM_CHK_EN
        ,
        .proto_err  (proto_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_st;
        st_sos = 1'b0; st_eos = 1'b0; st_A = '0; st_FV_data = '0;
    endtask

    task automatic load_lines(input logic [A_W-1:0] a0, input int n);
        logic [A_W-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = a0 + A_W'(i);
            st_sos = (i == 0); st_eos = (i == n - 1); st_A = a; st_FV_data = 64'(a);
            #3;
            chk("ld_en", {sram_CEN, sram_WEN}, 2'b00);
            chk("ld_addr", sram_addr, a);
            chk("ld_data", sram_D, 64'(a));
            chk("ld_not_ready", rd_ready, 1'b0);
            tick;
        end
        clear_st;
    endtask

    task automatic do_read(input logic [NODE_W-1:0] node, input logic [TAG_W-1:0] tag,
                           input logic [FVNUM_W-1:0] fvn, input logic [63:0] base, input int nb);
        rd_req = 1'b1; rd_node = node; rd_PE_tag = tag; fv_num = fvn;
        #3;
        if (fvn != 0) begin
            chk("rd_issue", {sram_CEN, sram_WEN}, 2'b01);
            chk("rd_addr0", sram_addr, {node, 3'b000});
        end else begin
            chk("rd_noissue", sram_CEN, 1'b1);
        end
        tick;
        rd_req = 1'b0;
        #3;
        chk("rd_lat_sos", pe_sos, 1'b0);
        chk("rd_busy", rd_ready, 1'b0);
        tick;
        for (int b = 0; b < nb; b++) begin
            #3;
            chk("rd_sos", pe_sos, b == 0);
            chk("rd_eos", pe_eos, b == nb - 1);
            chk("rd_data", pe_FV_data, (fvn == 0) ? 64'd0 : base + 64'(b));
            chk("rd_tag", pe_PE_tag, tag);
            tick;
        end
        #3;
        chk("rd_back_ready", rd_ready, 1'b1);
        chk("rd_quiet", {pe_sos, pe_eos}, 2'b00);
        tick;
    endtask

    initial begin
        logic [A_W-1:0] skip_a [5];
        skip_a[0] = 7'h00; skip_a[1] = 7'h01; skip_a[2] = 7'h02; skip_a[3] = 7'h03; skip_a[4] = 7'h05;
        reset_n = 1'b0; clear_st;
        fv_num = '0; rd_req = 1'b0; rd_node = '0; rd_PE_tag = '0;
        #3;
        chk("rst_cen_wen", {sram_CEN, sram_WEN}, 2'b11);
        chk("rst_addr", sram_addr, 0);
        chk("rst_d", sram_D, 0);
        chk("rst_pe", {pe_sos, pe_eos, pe_PE_tag}, 0);
        chk("rst_pe_data", pe_FV_data, 0);
        chk("rst_ready_abort", {rd_ready, rd_abort}, 2'b00);
        tick;
        reset_n = 1'b1;
        tick;

        load_lines(7'h00, 16);
        #3;
        chk("load_ready", rd_ready, 1'b1);
        tick;

        do_read(4'd1, 2'd2, 5'd16, 64'h08, 8);
        do_read(4'd0, 2'd1, 5'd5,  64'h00, 3);
        do_read(4'd1, 2'd3, 5'd2,  64'h08, 1);
        do_read(4'd0, 2'd0, 5'd0,  64'h00, 1);

        rd_req = 1'b1; rd_node = 4'd0; rd_PE_tag = 2'd1; fv_num = 5'd16;
        #3; tick;
        rd_req = 1'b0;
        #3; tick;
        #3;
        chk("ab_beat1_sos", pe_sos, 1'b1);
        tick;
        st_sos = 1'b1; st_A = 7'h20; st_FV_data = 64'h20;
        #3;
        chk("ab_pulse", rd_abort, 1'b1);
        chk("ab_pe_frame", {pe_sos, pe_eos}, 2'b00);
        chk("ab_pe_data", pe_FV_data, 0);
        chk("ab_wr_en", {sram_CEN, sram_WEN}, 2'b00);
        chk("ab_wr_addr", sram_addr, 7'h20);
        chk("ab_wr_d", sram_D, 64'h20);
        tick;
        st_sos = 1'b0; st_eos = 1'b1; st_A = 7'h21; st_FV_data = 64'h21;
        #3;
        chk("ab_pulse_gone", rd_abort, 1'b0);
        chk("ab_no_eos", pe_eos, 1'b0);
        chk("ab_load_state", rd_ready, 1'b0);
        chk("ab_wr2_addr", sram_addr, 7'h21);
        tick;
        clear_st;
        #3;
        chk("ab_reload_ready", rd_ready, 1'b1);
        tick;
        do_read(4'd4, 2'd0, 5'd4, 64'h20, 2);

        st_sos = 1'b1; st_A = 7'h30; st_FV_data = 64'h30;
        #3; tick;
        st_sos = 1'b0; st_A = 7'h31; st_FV_data = 64'h31;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_cen_wen", {sram_CEN, sram_WEN}, 2'b11);
        chk("arst_addr", sram_addr, 0);
        chk("arst_d", sram_D, 0);
        chk("arst_flags", {rd_ready, rd_abort, pe_sos, pe_eos}, 4'b0000);
        tick; tick;
        reset_n = 1'b1; clear_st;
        tick;
        rd_req = 1'b1; rd_node = 4'd0; fv_num = 5'd4;
        #3;
        chk("arst_req_ignored", sram_CEN, 1'b1);
        tick;
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("arst_no_rsp", {pe_sos, rd_ready}, 2'b00);
            tick;
        end

`ifdef SMFV_STREAM_CHK_EN
        #3;
        chk("chk_clean", proto_err, 1'b0);
        tick;
`endif
        for (int i = 0; i < 5; i++) begin
            st_sos = (i == 0); st_eos = (i == 4); st_A = skip_a[i]; st_FV_data = 64'(skip_a[i]);
            #3;
            chk("skip_wr_en", {sram_CEN, sram_WEN}, 2'b00);
            chk("skip_wr_addr", sram_addr, skip_a[i]);
`ifdef SMFV_STREAM_CHK_EN
            if (i == 4) chk("chk_pre_skip", proto_err, 1'b0);
`endif
            tick;
        end
        clear_st;
        #3;
        chk("skip_ready", rd_ready, 1'b1);
`ifdef SMFV_STREAM_CHK_EN
        chk("chk_set", proto_err, 1'b1);
        tick; tick; tick;
        #3;
        chk("chk_sticky", proto_err, 1'b1);
`endif
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
